// File: rtl/mem_slot_sched.sv
// rtl/mem_slot_sched.sv - Mac Plus 4-phase bus slot timing and extra-cycle DMA channel arbiter
// Video/CPU/extra bus ownership per 16-clk frame; extra cycle granted to one channel with address offset.
module mem_slot_sched #(
    parameter int                         ADDR_W   = 22,
    parameter int                         NUM_CH   = 4,
    parameter logic [NUM_CH*ADDR_W-1:0]   CH_BASE  = '0,
    parameter int                         ARB_MODE = 1
) (
    input  logic                       clk,
    input  logic                       _reset,
    input  logic [NUM_CH-1:0]          ch_req,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    output logic [NUM_CH-1:0]          ch_ack,
    output logic [NUM_CH-1:0]          ch_done,
    output logic [ADDR_W-1:0]          extraAddr,
    output logic                       extraValid,
    output logic [1:0]                 busPhase,
    output logic [1:0]                 busCycle,
    output logic                       clk8_en_p,
    output logic                       clk8_en_n,
    output logic                       memoryLatch,
    output logic                       videoBusControl,
    output logic                       cpuBusControl,
    output logic                       extraBusControl
);

    localparam int PW = $clog2(NUM_CH);

    logic [PW-1:0]     rrPtr;
    logic [PW-1:0]     slotCnt;
    logic [PW-1:0]     rrPick;
    logic              rrFound;
    logic [PW:0]       rrSum;
    logic [PW-1:0]     grantIdx;
    logic              grantValid;
    logic [ADDR_W-1:0] selAddr;
    logic [ADDR_W-1:0] selBase;
    logic [NUM_CH-1:0] grantOneHot;
    logic              sampleEdge;
    logic              leaveExtra;

    function automatic logic [PW-1:0] wrapInc(input logic [PW-1:0] x);
        wrapInc = (x == PW'(NUM_CH - 1)) ? '0 : x + PW'(1);
    endfunction

    assign sampleEdge = (busPhase == 2'd3) && (busCycle == 2'd1);
    assign leaveExtra = (busPhase == 2'd3) && (busCycle == 2'd2);

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            busPhase <= 2'd0;
            busCycle <= 2'd0;
        end else begin
            busPhase <= busPhase + 2'd1;
            if (busPhase == 2'd3) begin
                busCycle <= busCycle + 2'd1;
            end
        end
    end

    // Round-robin search starting at rrPtr; explicit wrap keeps non-power-of-two NUM_CH correct.
    always_comb begin
        rrFound = 1'b0;
        rrPick  = '0;
        rrSum   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            rrSum = {1'b0, rrPtr} + (PW+1)'(k);
            if (rrSum >= (PW+1)'(NUM_CH)) begin
                rrSum = rrSum - (PW+1)'(NUM_CH);
            end
            if (!rrFound && ch_req[rrSum[PW-1:0]]) begin
                rrFound = 1'b1;
                rrPick  = rrSum[PW-1:0];
            end
        end
    end

    always_comb begin
        grantIdx   = (ARB_MODE != 0) ? rrPick  : slotCnt;
        grantValid = (ARB_MODE != 0) ? rrFound : 1'b1;
    end

    always_comb begin
        selAddr     = '0;
        selBase     = '0;
        grantOneHot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grantIdx == PW'(i)) begin
                selAddr        = ch_addr[i*ADDR_W +: ADDR_W];
                selBase        = CH_BASE[i*ADDR_W +: ADDR_W];
                grantOneHot[i] = 1'b1;
            end
        end
    end

    // Legacy mode acks its slot whether or not the channel asked for it.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            ch_ack    <= '0;
            extraAddr <= '0;
            rrPtr     <= '0;
            slotCnt   <= '0;
        end else if (sampleEdge) begin
            if (grantValid) begin
                ch_ack    <= grantOneHot;
                extraAddr <= selAddr + selBase;
            end else begin
                ch_ack    <= '0;
            end
            if (ARB_MODE != 0) begin
                if (rrFound) begin
                    rrPtr <= wrapInc(rrPick);
                end
            end else begin
                slotCnt <= wrapInc(slotCnt);
            end
        end else if (leaveExtra) begin
            ch_ack <= '0;
        end
    end

    assign ch_done         = leaveExtra ? ch_ack : '0;
    assign extraValid      = |ch_ack;
    assign clk8_en_p       = (busPhase == 2'd3);
    assign clk8_en_n       = (busPhase == 2'd1);
    assign memoryLatch     = (busPhase == 2'd3);
    assign videoBusControl = (busCycle == 2'd0);
    assign cpuBusControl   = (busCycle == 2'd1) || (busCycle == 2'd3);
    assign extraBusControl = (busCycle == 2'd2);

endmodule

// File: tb/tb_mem_slot_sched.sv
// tb/tb_mem_slot_sched.sv - scoreboard bench for mem_slot_sched (round-robin and fixed-rotation instances)
module tb_mem_slot_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  chReq = 4'b0000;
    logic [87:0] chAddr = {22'h000002, 22'h000123, 22'h000020, 22'h000010};
    logic [3:0]  chAck, chDone;
    logic [21:0] extraAddr;
    logic        extraValid;
    logic [1:0]  busPhase, busCycle;
    logic        clk8p, clk8n, memLatch, vidCtl, cpuCtl, extCtl;

    logic [2:0]  req0 = 3'b000;
    logic [65:0] addr0 = '0;
    logic [2:0]  ack0, done0;
    logic [21:0] extraAddr0;
    logic        valid0;
    logic [1:0]  phase0, cycle0;
    logic        p0, n0, latch0, vid0, cpu0, ext0;

    typedef struct packed {
        logic [3:0]  ack;
        logic [21:0] addr;
    } exp_t;
    exp_t expQ[$];
    exp_t cur;
    logic [3:0] lastAck = 4'b0000;

    int  checkCnt = 0;
    int  passCnt  = 0;
    logic monEn = 1'b0;
    logic [3:0] mCnt;
    int  slotM = 0;

    mem_slot_sched #(.ADDR_W(22), .NUM_CH(4),
        .CH_BASE({22'h3FFFFF, 22'h100000, 22'h000000, 22'h000000}), .ARB_MODE(1)) dut (
        .clk(clk), ._reset(rst_n), .ch_req(chReq), .ch_addr(chAddr),
        .ch_ack(chAck), .ch_done(chDone), .extraAddr(extraAddr), .extraValid(extraValid),
        .busPhase(busPhase), .busCycle(busCycle), .clk8_en_p(clk8p), .clk8_en_n(clk8n),
        .memoryLatch(memLatch), .videoBusControl(vidCtl), .cpuBusControl(cpuCtl),
        .extraBusControl(extCtl));

    mem_slot_sched #(.ADDR_W(22), .NUM_CH(3),
        .CH_BASE({22'h000003, 22'h000002, 22'h000001}), .ARB_MODE(0)) dut0 (
        .clk(clk), ._reset(rst_n), .ch_req(req0), .ch_addr(addr0),
        .ch_ack(ack0), .ch_done(done0), .extraAddr(extraAddr0), .extraValid(valid0),
        .busPhase(phase0), .busCycle(cycle0), .clk8_en_p(p0), .clk8_en_n(n0),
        .memoryLatch(latch0), .videoBusControl(vid0), .cpuBusControl(cpu0),
        .extraBusControl(ext0));

    always #5 clk = ~clk;

    // Independent clock-count model of the 16-clk slot frame.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mCnt <= 4'd0;
        else        mCnt <= mCnt + 4'd1;
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    always @(negedge clk) begin
        if (rst_n && monEn) begin
            checkVal("timing",
                {busPhase, busCycle, clk8p, clk8n, memLatch, vidCtl, cpuCtl, extCtl,
                 (busCycle != 2'd2) && (|chAck), extraValid != (|chAck), phase0, cycle0},
                {mCnt[1:0], mCnt[3:2], mCnt[1:0] == 2'd3, mCnt[1:0] == 2'd1, mCnt[1:0] == 2'd3,
                 mCnt[3:2] == 2'd0, (mCnt[3:2] == 2'd1) || (mCnt[3:2] == 2'd3), mCnt[3:2] == 2'd2,
                 1'b0, 1'b0, mCnt[1:0], mCnt[3:2]});
            if (mCnt == 4'd8) begin
                if (expQ.size() == 0) begin
                    checkVal("sb_underflow", 64'(chAck), 64'hFFFF);
                    lastAck = 4'b0000;
                end else begin
                    cur = expQ.pop_front();
                    lastAck = cur.ack;
                    checkVal("ack", 64'(chAck), 64'(cur.ack));
                    if (cur.ack != 4'b0000) checkVal("addr", 64'(extraAddr), 64'(cur.addr));
                end
                checkVal("ack_fixed", 64'(ack0), 64'(3'b001 << slotM));
                checkVal("addr_fixed", 64'(extraAddr0), 64'(slotM + 1));
            end
            if (mCnt == 4'd11) begin
                checkVal("done", 64'(chDone), 64'(lastAck));
                checkVal("done_fixed", 64'(done0), 64'(3'b001 << slotM));
            end
            if (mCnt == 4'd12) begin
                checkVal("ack_clear", 64'({chAck, chDone, ack0, done0}), 64'(0));
                slotM = (slotM == 2) ? 0 : slotM + 1;
            end
        end
    end

    task automatic runFrame(input logic [3:0] req, input int dropMode,
                            input logic [3:0] eAck, input logic [21:0] eAddr);
        exp_t e;
        e.ack  = eAck;
        e.addr = eAddr;
        expQ.push_back(e);
        chReq = req;
        do @(negedge clk); while (mCnt != 4'd4);
        if (dropMode == 1) chReq = 4'b0000;
        do @(negedge clk); while (mCnt != 4'd9);
        if (dropMode == 2) chReq = 4'b0000;
        do @(negedge clk); while (mCnt != 4'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkVal({tag, "_main"}, {busPhase, busCycle, vidCtl, clk8p, clk8n, memLatch,
                                  chAck, chDone, extraValid, extraAddr},
                 64'({2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 22'd0}));
        checkVal({tag, "_fixed"}, {phase0, cycle0, vid0, p0, n0, latch0, ack0, done0, valid0, extraAddr0},
                 64'({2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 22'd0}));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkResetState("reset");
        #2 rst_n = 1'b1;
        monEn = 1'b1;

        for (int i = 0; i < 4; i++) runFrame(4'b0000, 0, 4'b0000, 22'h0);

        runFrame(4'b1111, 0, 4'b0001, 22'h000010);
        runFrame(4'b1111, 0, 4'b0010, 22'h000020);
        runFrame(4'b1111, 0, 4'b0100, 22'h100123);
        runFrame(4'b1111, 0, 4'b1000, 22'h000001);
        runFrame(4'b1111, 0, 4'b0001, 22'h000010);

        runFrame(4'b0100, 0, 4'b0100, 22'h100123);
        runFrame(4'b0100, 0, 4'b0100, 22'h100123);
        runFrame(4'b0001, 0, 4'b0001, 22'h000010);

        runFrame(4'b0010, 2, 4'b0010, 22'h000020);
        runFrame(4'b0000, 0, 4'b0000, 22'h0);
        runFrame(4'b1000, 1, 4'b0000, 22'h0);

        begin
            exp_t e;
            e.ack  = 4'b0010;
            e.addr = 22'h000020;
            expQ.push_back(e);
            chReq = 4'b0010;
            do @(negedge clk); while (mCnt != 4'd9);
            checkVal("pre_abort_ack", 64'(chAck), 64'(4'b0010));
            #2 rst_n = 1'b0;
            slotM = 0;
            #1 checkVal("abort", {chAck, chDone, busPhase, busCycle, extraValid},
                        64'({4'd0, 4'd0, 2'd0, 2'd0, 1'b0}));
            repeat (2) @(negedge clk);
            checkResetState("abort_hold");
            #2 rst_n = 1'b1;
        end
        runFrame(4'b0010, 0, 4'b0010, 22'h000020);
        runFrame(4'b0000, 0, 4'b0000, 22'h0);

        checkVal("sb_empty", 64'(expQ.size()), 64'(0));
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
